// File: rtl/stack_unit.sv
`timescale 1ns/1ps
// stack_unit: operand stack for the stack-based multicycle datapath.
// Accepts one Push/Pop/ToS command per cycle from the controller, keeps the
// stack pointer (which doubles as occupancy) and sticky overflow/underflow
// flags, and drives the top entry combinationally so A/B can latch it in the
// same state that asserts ToS.
module stack_unit #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             tos,
    input  logic [WIDTH-1:0] din,
    input  logic             clr_err,
    output logic [WIDTH-1:0] dout,
    output logic [AW:0]      count,
    output logic             empty,
    output logic             full,
    output logic             overflow,
    output logic             underflow
);

    localparam logic [AW:0] SP_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] SP_ONE  = (AW+1)'(1);

    // storage; deliberately not reset, slots above sp are don't-care
    logic [WIDTH-1:0] mem_q [DEPTH];

    // sp is both the next free slot and the occupancy
    logic [AW:0]      sp_q, sp_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;

    logic             stk_empty, stk_full;
    logic [AW-1:0]    top_idx;
    logic             wr_en;
    logic [AW-1:0]    wr_idx;
    logic             ovf_set, unf_set;

    assign stk_empty = (sp_q == '0);
    assign stk_full  = (sp_q == SP_FULL);

    // sp-1 truncated to an index; only meaningful when not empty
    assign top_idx   = AW'(sp_q - SP_ONE);

    // Combinational top-of-stack read: always the pre-edge top, gated by tos
    always_comb begin
        dout = '0;
        if (tos && !stk_empty)
            dout = mem_q[top_idx];
    end

    // Command decode: next sp, memory write and error events
    always_comb begin
        sp_d    = sp_q;
        wr_en   = 1'b0;
        wr_idx  = sp_q[AW-1:0];
        ovf_set = 1'b0;
        unf_set = 1'b0;
        unique case ({push, pop})
            2'b10: begin
                if (stk_full) begin
                    ovf_set = 1'b1;
                end else begin
                    wr_en  = 1'b1;
                    wr_idx = sp_q[AW-1:0];
                    sp_d   = sp_q + SP_ONE;
                end
            end
            2'b01: begin
                if (stk_empty)
                    unf_set = 1'b1;
                else
                    sp_d = sp_q - SP_ONE;
            end
            2'b11: begin
                // replace-top; on an empty stack this degenerates to a push
                wr_en = 1'b1;
                if (stk_empty) begin
                    wr_idx = '0;
                    sp_d   = SP_ONE;
                end else begin
                    wr_idx = top_idx;
                end
            end
            default: ;
        endcase
        // reading an empty stack is an error regardless of push/pop
        if (tos && stk_empty)
            unf_set = 1'b1;
    end

    // Sticky flags: a new event in the same cycle beats clr_err
    always_comb begin
        ovf_d = ovf_set | (ovf_q & ~clr_err);
        unf_d = unf_set | (unf_q & ~clr_err);
    end

    // Pointer and flag state with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp_q  <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            sp_q  <= sp_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    // Storage write. While rst is high sp is pinned at 0, so any write lands
    // in slot 0, which is invalid at that point and invisible until a later
    // push overwrites it; no reset gating is needed here.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem_q[wr_idx] <= din;
    end

    assign count     = sp_q;
    assign empty     = stk_empty;
    assign full      = stk_full;
    assign overflow  = ovf_q;
    assign underflow = unf_q;

endmodule

// File: tb/tb_stack_unit.sv
`timescale 1ns/1ps
// tb_stack_unit: directed scoreboard bench for stack_unit at DEPTH=8.
// The driver issues one command per cycle and queues what the outputs must
// show during that cycle; the monitor pops and compares on the falling edge.
module tb_stack_unit;

    localparam int WIDTH = 8;
    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic             clk;
    logic             rst;
    logic             push, pop, tos, clr_err;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] dout;
    logic [AW:0]      count;
    logic             empty, full, overflow, underflow;

    typedef struct {
        string      nm;
        logic [7:0] d;
        logic [3:0] c;
        logic       o;
        logic       u;
    } exp_t;

    exp_t sb[$];
    logic chk;
    int   n_total;
    int   n_pass;

    stack_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .tos       (tos),
        .din       (din),
        .clr_err   (clr_err),
        .dout      (dout),
        .count     (count),
        .empty     (empty),
        .full      (full),
        .overflow  (overflow),
        .underflow (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input string fld,
                         input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s.%s act=%0h exp=%0h", nm, fld, act, exp);
    endtask

    // Monitor: compare the DUT against the oldest queued expectation
    always @(negedge clk) begin
        if (chk) begin
            if (sb.size() == 0) begin
                check("scoreboard", "underrun", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check(e.nm, "dout",      32'(dout),      32'(e.d));
                check(e.nm, "count",     32'(count),     32'(e.c));
                check(e.nm, "empty",     32'(empty),     32'(e.c == 4'd0));
                check(e.nm, "full",      32'(full),      32'(e.c == 4'd8));
                check(e.nm, "overflow",  32'(overflow),  32'(e.o));
                check(e.nm, "underflow", 32'(underflow), 32'(e.u));
            end
        end
    end

    // One command cycle; expected values describe the outputs during it
    task automatic cmd(input logic r, input logic ps, input logic pp,
                       input logic t, input logic cl, input logic [7:0] di,
                       input string nm, input logic [7:0] ed,
                       input logic [3:0] ec, input logic eo, input logic eu);
        @(posedge clk);
        #1;
        rst = r; push = ps; pop = pp; tos = t; clr_err = cl; din = di;
        sb.push_back('{nm, ed, ec, eo, eu});
        chk = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        n_total = 0; n_pass = 0; chk = 1'b0;
        rst = 1'b1; push = 1'b0; pop = 1'b0; tos = 1'b0; clr_err = 1'b0;
        din = '0;

        // commands under reset must not take effect
        cmd(1,1,0,1,0,8'hEE,"rst_hold", 8'h00,0,0,0);
        cmd(0,0,0,0,0,8'h00,"rst_rel",  8'h00,0,0,0);

        // push three, read top, pop back out with tos
        cmd(0,1,0,0,0,8'h11,"push11",   8'h00,0,0,0);
        cmd(0,1,0,0,0,8'h22,"push22",   8'h00,1,0,0);
        cmd(0,1,0,0,0,8'h33,"push33",   8'h00,2,0,0);
        cmd(0,0,0,1,0,8'h00,"tos3",     8'h33,3,0,0);
        cmd(0,0,1,1,0,8'h00,"pop33",    8'h33,3,0,0);
        cmd(0,0,1,1,0,8'h00,"pop22",    8'h22,2,0,0);
        cmd(0,0,1,1,0,8'h00,"pop11",    8'h11,1,0,0);
        cmd(0,0,0,0,0,8'h00,"drained",  8'h00,0,0,0);

        // fill to full, overflow, clear
        for (int i = 0; i < 8; i++)
            cmd(0,1,0,0,0,8'(i+1),"fill", 8'h00,4'(i),0,0);
        cmd(0,1,0,0,0,8'h99,"push_full",8'h00,8,0,0);
        cmd(0,0,0,1,0,8'h00,"ovf_tos",  8'h08,8,1,0);
        cmd(0,0,0,0,1,8'h00,"clr_ovf",  8'h00,8,1,0);
        cmd(0,0,0,0,0,8'h00,"ovf_clr",  8'h00,8,0,0);
        for (int i = 0; i < 8; i++)
            cmd(0,0,1,1,0,8'h00,"drain", 8'(8-i),4'(8-i),0,0);

        // underflow, set beats clear, tos-only underflow
        cmd(0,0,1,0,0,8'h00,"pop_empty",8'h00,0,0,0);
        cmd(0,0,0,1,0,8'h00,"tos_empty",8'h00,0,0,1);
        cmd(0,0,1,0,1,8'h00,"pop_clr",  8'h00,0,0,1);
        cmd(0,0,0,0,0,8'h00,"set_wins", 8'h00,0,0,1);
        cmd(0,0,0,0,1,8'h00,"clr_unf",  8'h00,0,0,1);
        cmd(0,0,0,1,0,8'h00,"tos_only", 8'h00,0,0,0);
        cmd(0,0,0,0,1,8'h00,"tos_set",  8'h00,0,0,1);

        // replace-top, and push+pop on empty
        cmd(0,1,0,0,0,8'h05,"push05",   8'h00,0,0,0);
        cmd(0,1,0,0,0,8'h07,"push07",   8'h00,1,0,0);
        cmd(0,1,1,0,0,8'hAA,"repl",     8'h00,2,0,0);
        cmd(0,0,1,1,0,8'h00,"popAA",    8'hAA,2,0,0);
        cmd(0,0,1,1,0,8'h00,"pop05",    8'h05,1,0,0);
        cmd(0,1,1,0,0,8'h3C,"pp_empty", 8'h00,0,0,0);
        cmd(0,0,1,1,0,8'h00,"pop3C",    8'h3C,1,0,0);

        // async reset mid-cycle with flags set and stack non-empty
        cmd(0,0,0,1,0,8'h00,"tos_e2",   8'h00,0,0,0);
        cmd(0,1,0,0,0,8'h44,"push44a",  8'h00,0,0,1);
        cmd(0,1,0,0,0,8'h44,"push44b",  8'h00,1,0,1);
        @(posedge clk);
        #1;
        push = 1'b1; pop = 1'b0; tos = 1'b0; clr_err = 1'b0; din = 8'h44;
        #2;
        rst = 1'b1;
        sb.push_back('{"async_rst", 8'h00, 4'd0, 1'b0, 1'b0});
        cmd(1,1,0,0,0,8'h44,"rst_push", 8'h00,0,0,0);
        cmd(0,0,0,0,0,8'h00,"rst_rel2", 8'h00,0,0,0);
        cmd(0,1,0,0,0,8'h55,"push55",   8'h00,0,0,0);
        cmd(0,0,0,1,0,8'h00,"tos55",    8'h55,1,0,0);

        @(posedge clk);
        #1;
        chk = 1'b0;
        push = 1'b0; pop = 1'b0; tos = 1'b0; clr_err = 1'b0;
        @(posedge clk);
        check("scoreboard", "leftover", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/stack_unit.md
Name: stack_unit

Overview:
- Hardware operand stack for the stack-based multicycle datapath.
- Responder to the controller's Push/Pop/ToS command strobes: stores operands pushed from memory or the ALU, and presents top-of-stack to the A/B latches.
- Maintains the stack pointer, occupancy, and sticky overflow/underflow error flags.

Parameters:
- WIDTH, 8, data word width in bits.
- DEPTH, 16, number of stack entries; must be a power of 2, minimum 2.
- AW, $clog2(DEPTH), stack pointer index width (derived, do not override).

Ports:
- clk  input  1  clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- push  input  1  write din onto the stack at the next rising edge.
- pop  input  1  remove the top entry at the next rising edge.
- tos  input  1  drive the current top entry on dout this cycle.
- din  input  WIDTH  data to push.
- clr_err  input  1  synchronous clear of the sticky error flags.
- dout  output  WIDTH  top-of-stack data (combinational).
- count  output  AW+1  number of valid entries, 0..DEPTH.
- empty  output  1  count==0.
- full  output  1  count==DEPTH.
- overflow  output  1  sticky: a push was dropped.
- underflow  output  1  sticky: a pop or tos hit an empty stack.

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk.
  - On rst: sp=0, count=0, overflow=0, underflow=0; empty=1, full=0; dout=0.
  - Storage array is not reset; contents are undefined until written.
  - rst overrides any command in flight. No command issued in a cycle where rst is high takes effect.
- Storage: array mem[0..DEPTH-1]. sp (AW+1 bits) = count = index of the next free slot. Top entry is mem[sp-1].
- dout (combinational, zero latency):
  - dout = mem[sp-1] when tos=1 and not empty; otherwise dout=0.
  - Same-cycle read lets the controller assert ToS and latch A/B in the same state.
  - dout always reflects the pre-edge top, even when pop or push is asserted in the same cycle.
- Commands are sampled at the rising edge and evaluated in priority order:
  1. push=1, pop=0, not full: mem[sp]<=din; sp<=sp+1.
  2. push=1, pop=0, full: no write; sp unchanged; overflow<=1.
  3. pop=1, push=0, not empty: sp<=sp-1. Popped entry remains in the array but is invalid.
  4. pop=1, push=0, empty: sp unchanged; underflow<=1.
  5. push=1, pop=1, not empty: replace top, mem[sp-1]<=din; sp unchanged. No flag set, even when full.
  6. push=1, pop=1, empty: behaves as a plain push (mem[0]<=din, sp<=1). No underflow.
  7. tos=1 while empty: underflow<=1. Applies in any combination with the rules above.
- sp never wraps: it saturates at 0 and at DEPTH. The sticky flags are the only indication.
- clr_err=1 at an edge clears overflow and underflow. If an error event occurs in the same cycle, the set wins.
- count=sp; empty and full are decoded combinationally from sp.
- Throughput: one command per cycle; back-to-back push/pop is allowed with no bubbles.

Test Plan:
- DEPTH=8. After rst, push 0x11, 0x22, 0x33 on consecutive cycles, then tos=1 -> dout=0x33, count=3, empty=0, full=0.
- From that state, pop with tos=1 for 3 cycles -> dout=0x33, 0x22, 0x11 in order; then count=0, empty=1, no underflow.
- Push 0x01..0x08 -> full=1, count=8. A 9th push of 0x99 -> overflow=1, count=8, tos gives 0x08. clr_err=1 -> overflow=0.
- On an empty stack, assert pop, then tos -> underflow=1, count=0, dout=0. pop and clr_err in the same cycle -> underflow stays 1.
- With stack [0x05,0x07], assert push=1, pop=1, din=0xAA -> count=2, top=0xAA, next entry=0x05. On an empty stack, push=1, pop=1, din=0x3C -> count=1, top=0x3C.
- Push 0x44 twice, then raise rst mid-cycle while push=1 -> count=0, empty=1, flags=0 immediately (asynchronous). After release, push 0x55 -> count=1, tos gives 0x55.
